// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU/load writebacks (mem has priority) into a FIFO drained onto the bank's single write port.
// Accept at edge N, registered write presented after N+1; ready drops when the FIFO is full, wb_hold stalls draining.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  input  logic                     wb_hold,
  output logic                     we,
  output logic [4:0]               a3,
  output logic [XLEN-1:0]          wd3,
  input  logic [4:0]               q_rs1,
  input  logic [4:0]               q_rs2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] live;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            full;
  logic            mem_fire;
  logic            alu_fire;
  logic            acc;
  logic            push;
  logic            pop;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;

  // Ready depends only on registered count, so a same-cycle pop never raises it.
  assign full      = (count == FULL_CNT);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign acc       = mem_fire || alu_fire;
  assign in_rd     = mem_fire ? mem_rd : alu_rd;
  assign in_data   = mem_fire ? mem_data : alu_data;
  // Writes to x0 complete the handshake but are never queued.
  assign push      = acc && (in_rd != 5'd0);
  assign pop       = (count != '0) && !wb_hold;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= in_rd;
      data_q[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= '0;
      we     <= 1'b0;
      a3     <= 5'd0;
      wd3    <= '0;
    end else begin
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        live[rd_ptr] <= 1'b0;
        we           <= 1'b1;
        a3           <= rd_q[rd_ptr];
        wd3          <= data_q[rd_ptr];
      end else begin
        we <= 1'b0;
      end
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        live[wr_ptr] <= 1'b1;
      end
      if (push && !pop)
        count <= count + ONE_CNT;
      else if (!push && pop)
        count <= count - ONE_CNT;
    end
  end

  // A register is busy while queued, while on the write port, or while being accepted.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && rd_q[i] == q_rs1) busy1 = 1'b1;
      if (live[i] && rd_q[i] == q_rs2) busy2 = 1'b1;
    end
    if (we && a3 == q_rs1) busy1 = 1'b1;
    if (we && a3 == q_rs2) busy2 = 1'b1;
    if (acc && in_rd == q_rs1) busy1 = 1'b1;
    if (acc && in_rd == q_rs2) busy2 = 1'b1;
    if (q_rs1 == 5'd0) busy1 = 1'b0;
    if (q_rs2 == 5'd0) busy2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, alu_ready, mem_valid, mem_ready, wb_hold, we, busy1, busy2;
  logic [4:0]      alu_rd, mem_rd, a3, q_rs1, q_rs2;
  logic [XLEN-1:0] alu_data, mem_data, wd3;
  logic [2:0]      count;

  int checks = 0;
  int failures = 0;

  wb_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_hold(wb_hold), .we(we), .a3(a3), .wd3(wd3),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .busy1(busy1), .busy2(busy2), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending writes plus the last write-port value.
  typedef struct packed { logic [4:0] rd; logic [XLEN-1:0] d; } ent_t;
  ent_t            mq[$];
  logic            exp_we = 1'b0;
  logic [4:0]      exp_a3 = 5'd0;
  logic [XLEN-1:0] exp_wd3 = '0;

  function automatic bit m_mem_acc();
    return mem_valid && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_alu_acc();
    return alu_valid && !mem_valid && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_busy(input logic [4:0] q);
    bit b = 0;
    if (q == 5'd0) return 0;
    foreach (mq[i]) if (mq[i].rd == q) b = 1;
    if (exp_we && exp_a3 == q) b = 1;
    if (m_mem_acc() && mem_rd == q) b = 1;
    if (m_alu_acc() && alu_rd == q) b = 1;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    ent_t e;
    bit   a;
    if (!rst_n) begin
      mq.delete();
      exp_we  = 1'b0;
      exp_a3  = 5'd0;
      exp_wd3 = '0;
    end else begin
      a = m_mem_acc() || m_alu_acc();
      e = m_mem_acc() ? '{mem_rd, mem_data} : '{alu_rd, alu_data};
      if (mq.size() != 0 && !wb_hold) begin
        exp_we  = 1'b1;
        exp_a3  = mq[0].rd;
        exp_wd3 = mq[0].d;
        void'(mq.pop_front());
      end else begin
        exp_we = 1'b0;
      end
      if (a && e.rd != 5'd0) mq.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md,
                       input logic hold);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    wb_hold = hold;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; q_rs1 = 5'd0; q_rs2 = 5'd0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", we); end
    checks++; if (a3 !== 5'd0) begin failures++; $display("FAIL reset_a3 got=%0d exp=0", a3); end
    checks++; if (wd3 !== 32'd0) begin failures++; $display("FAIL reset_wd3 got=%h exp=0", wd3); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b%0b exp=11", mem_ready, alu_ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", alu_ready); end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (count !== 3'd1 || we !== 1'b0) begin failures++; $display("FAIL single_queued count=%0d we=%0b exp 1/0", count, we); end
    step();
    checks++; if (we !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin failures++; $display("FAIL single_write we=%0b a3=%0d wd3=%h exp 1/5/deadbeef", we, a3, wd3); end
    step();
    checks++; if (we !== 1'b0 || a3 !== 5'd5 || count !== 3'd0) begin failures++; $display("FAIL single_after we=%0b a3=%0d count=%0d exp 0/5/0", we, a3, count); end
  endtask

  task automatic test_priority();
    drive(1, 5'd4, 32'h22, 1, 5'd3, 32'h11, 0);
    #1;
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin failures++; $display("FAIL prio_ready alu=%0b mem=%0b exp 0/1", alu_ready, mem_ready); end
    step();
    drive(1, 5'd4, 32'h22, 0, 0, 0, 0);
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL prio_alu_next got=%0b exp=1", alu_ready); end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (we !== 1'b1 || a3 !== 5'd3 || wd3 !== 32'h11) begin failures++; $display("FAIL prio_first we=%0b a3=%0d wd3=%h exp 1/3/11", we, a3, wd3); end
    step();
    checks++; if (we !== 1'b1 || a3 !== 5'd4 || wd3 !== 32'h22) begin failures++; $display("FAIL prio_second we=%0b a3=%0d wd3=%h exp 1/4/22", we, a3, wd3); end
    step();
    checks++; if (we !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL prio_idle we=%0b count=%0d exp 0/0", we, count); end
  endtask

  task automatic test_rd_zero();
    drive(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0);
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%0b exp=1", alu_ready); end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (count !== 3'd0 || we !== 1'b0) begin failures++; $display("FAIL x0_count count=%0d we=%0b exp 0/0", count, we); end
    step();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL x0_we got=%0b exp=0", we); end
  endtask

  task automatic test_full_hold();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 5'(i + 1), 32'(32'h100 + i), 0, 0, 0, 1);
      #1;
      checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL full_acc%0d got=%0b exp=1", i, alu_ready); end
      step();
    end
    drive(1, 5'd5, 32'h104, 0, 0, 0, 1);
    #1;
    checks++; if (count !== 3'd4 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin failures++; $display("FAIL full_stall count=%0d alu=%0b mem=%0b exp 4/0/0", count, alu_ready, mem_ready); end
    step();
    wb_hold = 1'b0;
    #1;
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL full_pop_noready got=%0b exp=0", alu_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) alu_valid = 1'b0;
      checks++; if (we !== 1'b1 || a3 !== 5'(i + 1) || wd3 !== 32'(32'h100 + i)) begin failures++; $display("FAIL full_drain%0d we=%0b a3=%0d wd3=%h exp 1/%0d", i, we, a3, wd3, i + 1); end
    end
    step();
    checks++; if (we !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL full_empty we=%0b count=%0d exp 0/0", we, count); end
  endtask

  task automatic test_busy();
    drive(1, 5'd7, 32'h77, 0, 0, 0, 1);
    q_rs1 = 5'd7; q_rs2 = 5'd0;
    #1;
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL busy_accept got=%0b exp=1", busy1); end
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (busy1 !== 1'b1 || busy2 !== 1'b0) begin failures++; $display("FAIL busy_queued b1=%0b b2=%0b exp 1/0", busy1, busy2); end
    wb_hold = 1'b0;
    step();
    checks++; if (we !== 1'b1 || busy1 !== 1'b1) begin failures++; $display("FAIL busy_port we=%0b b1=%0b exp 1/1", we, busy1); end
    step();
    checks++; if (we !== 1'b0 || count !== 3'd0 || busy1 !== 1'b0) begin failures++; $display("FAIL busy_clear we=%0b count=%0d b1=%0b exp 0/0/0", we, count, busy1); end
    q_rs1 = 5'd0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(10 + i), 32'(32'hA0 + i), 0, 0, 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL rmid_fill got=%0d exp=3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (we !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL rmid_async we=%0b count=%0d exp 0/0", we, count); end
    step();
    rst_n = 1'b1;
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (we !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL rmid_nowrite%0d we=%0b count=%0d exp 0/0", i, we, count); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)), $urandom,
            $urandom_range(2, 0) == 0, 5'($urandom_range(7, 0)), $urandom,
            $urandom_range(3, 0) == 0);
      q_rs1 = 5'($urandom_range(7, 0));
      q_rs2 = 5'($urandom_range(7, 0));
      #1;
      checks++; if (mem_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_mem_ready c=%0d got=%0b", c, mem_ready); end
      checks++; if (alu_ready !== (mq.size() < DEPTH && !mem_valid)) begin failures++; $display("FAIL rnd_alu_ready c=%0d got=%0b", c, alu_ready); end
      checks++; if (busy1 !== m_busy(q_rs1) || busy2 !== m_busy(q_rs2)) begin failures++; $display("FAIL rnd_busy c=%0d got=%0b%0b exp=%0b%0b", c, busy1, busy2, m_busy(q_rs1), m_busy(q_rs2)); end
      step();
      checks++; if (we !== exp_we) begin failures++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, we, exp_we); end
      checks++; if (a3 !== exp_a3 || wd3 !== exp_wd3) begin failures++; $display("FAIL rnd_port c=%0d got=%0d/%h exp=%0d/%h", c, a3, wd3, exp_a3, exp_wd3); end
      checks++; if (count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step();
    checks++; if (count !== 3'd0 || we !== 1'b0) begin failures++; $display("FAIL rnd_drain count=%0d we=%0b exp 0/0", count, we); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_priority();
    test_rd_zero();
    test_full_hold();
    test_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
